// File: rtl/lcd_spi_arbiter_if.sv
// Byte-stream bundle between the two LCD requesters, the arbiter and spi_master.
// Each requester presents valid/data/dc/last and sees ready; the arbiter presents
// start/data/dc to spi_master and sees the one-cycle spi_avail latch pulse.
interface lcd_spi_arbiter_if;
   logic       r0_valid;
   logic [7:0] r0_data;
   logic       r0_dc;
   logic       r0_last;
   logic       r0_ready;

   logic       r1_valid;
   logic [7:0] r1_data;
   logic       r1_dc;
   logic       r1_last;
   logic       r1_ready;

   logic       spi_start;
   logic [7:0] spi_data;
   logic       spi_dc;
   logic       spi_avail;

   // Arbiter side: consumes requester bytes, drives the spi_master request.
   modport slave (
      input  r0_valid, r0_data, r0_dc, r0_last,
      output r0_ready,
      input  r1_valid, r1_data, r1_dc, r1_last,
      output r1_ready,
      output spi_start, spi_data, spi_dc,
      input  spi_avail
   );

   // Environment side: the two requesters and spi_master.
   modport master (
      output r0_valid, r0_data, r0_dc, r0_last,
      input  r0_ready,
      output r1_valid, r1_data, r1_dc, r1_last,
      input  r1_ready,
      input  spi_start, spi_data, spi_dc,
      output spi_avail
   );
endinterface

// File: rtl/lcd_spi_arbiter.sv
// Two-requester burst arbiter in front of the single PCD8544 spi_master.
// A grant lasts a whole burst (until the byte tagged last is latched by the
// master) so command/address and data bytes of one requester never interleave.
// A watchdog forces release if the owner stalls in LOAD or SEND.
module lcd_spi_arbiter #(
   parameter logic [15:0] TIMEOUT        = 16'd50000,
   parameter bit          PRIORITY_FIXED = 1'b0
) (
   input  logic              clock,
   input  logic              Reset,
   lcd_spi_arbiter_if.slave  bus,
   output logic [1:0]        gnt,
   output logic              active,
   output logic              err,
   output logic [15:0]       byte_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t      state_q;
   logic        owner_q;
   logic        last_gnt_q;
   logic [1:0]  gnt_q;
   logic        active_q;
   logic        err_q;
   logic [15:0] byte_cnt_q;
   logic [15:0] wdog_q;
   logic [7:0]  hold_data_q;
   logic        hold_dc_q;
   logic        hold_last_q;
   logic        spi_start_q;

   logic        winner_d;
   logic        own_valid;
   logic [7:0]  own_data;
   logic        own_dc;
   logic        own_last;
   logic        accept;
   logic        wdog_expire;

   // Pick the IDLE winner and steer the current owner's byte stream.
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      winner_d  = 1'b0;
      own_valid = bus.r0_valid;
      own_data  = bus.r0_data;
      own_dc    = bus.r0_dc;
      own_last  = bus.r0_last;
      if (bus.r0_valid && bus.r1_valid) begin
         winner_d = PRIORITY_FIXED ? 1'b0 : ~last_gnt_q;
      end else begin
         winner_d = bus.r1_valid;
      end
      if (owner_q) begin
         own_valid = bus.r1_valid;
         own_data  = bus.r1_data;
         own_dc    = bus.r1_dc;
         own_last  = bus.r1_last;
      end
   end

   assign accept      = (state_q == LOAD) && own_valid;
   assign wdog_expire = (wdog_q == TIMEOUT - 16'd1);

   // Ready is combinational so a byte is taken in the same cycle LOAD is seen.
   assign bus.r0_ready = (state_q == LOAD) && !owner_q;
   assign bus.r1_ready = (state_q == LOAD) &&  owner_q;

   // Burst FSM with registered outputs, watchdog and byte counter.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_gnt_q  <= 1'b1;
         gnt_q       <= 2'b00;
         active_q    <= 1'b0;
         err_q       <= 1'b0;
         byte_cnt_q  <= '0;
         wdog_q      <= '0;
         // NOTE: the hold registers are plain flops, not a memory, so they are reset with the rest.
         hold_data_q <= '0;
         hold_dc_q   <= 1'b0;
         hold_last_q <= 1'b0;
         spi_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every branch reads the pre-edge state.
         case (state_q)
            IDLE: begin
               wdog_q <= '0;
               if (bus.r0_valid || bus.r1_valid) begin
                  owner_q  <= winner_d;
                  gnt_q    <= winner_d ? 2'b10 : 2'b01;
                  active_q <= 1'b1;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  hold_data_q <= own_data;
                  hold_dc_q   <= own_dc;
                  hold_last_q <= own_last;
                  spi_start_q <= 1'b1;
                  wdog_q      <= '0;
                  state_q     <= SEND;
               end else if (wdog_expire) begin
                  err_q      <= 1'b1;
                  last_gnt_q <= owner_q;
                  gnt_q      <= 2'b00;
                  active_q   <= 1'b0;
                  wdog_q     <= '0;
                  state_q    <= IDLE;
               end else begin
                  wdog_q <= wdog_q + 16'd1;
               end
            end
            SEND: begin
               if (bus.spi_avail) begin
                  spi_start_q <= 1'b0;
                  byte_cnt_q  <= byte_cnt_q + 16'd1;
                  wdog_q      <= '0;
                  if (hold_last_q) begin
                     last_gnt_q <= owner_q;
                     gnt_q      <= 2'b00;
                     active_q   <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     state_q <= LOAD;
                  end
               end else if (wdog_expire) begin
                  // The in-flight byte is dropped and not counted.
                  err_q       <= 1'b1;
                  spi_start_q <= 1'b0;
                  last_gnt_q  <= owner_q;
                  gnt_q       <= 2'b00;
                  active_q    <= 1'b0;
                  wdog_q      <= '0;
                  state_q     <= IDLE;
               end else begin
                  wdog_q <= wdog_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.spi_start = spi_start_q;
   assign bus.spi_data  = hold_data_q;
   assign bus.spi_dc    = hold_dc_q;
   assign gnt           = gnt_q;
   assign active        = active_q;
   assign err           = err_q;
   assign byte_cnt      = byte_cnt_q;

endmodule

// File: doc/lcd_spi_arbiter.md
# lcd_spi_arbiter

Two-requester arbiter that shares the single `spi_master` instance driving the PCD8544 (Nokia 5110) LCD. Requester 0 is the configuration/init sequencer and requester 1 is the sprite drawer. Each requester submits a stream of bytes tagged with the D/C flag and an end-of-burst marker. The block grants the SPI link to one requester per burst, so an address-set plus data burst is never interleaved. It feeds bytes to the master one at a time and releases the link on burst end or on a watchdog timeout.

## Interface
- `TIMEOUT`, 16'd50000: cycles the owner may stay in LOAD or SEND without progress before forced release.
- `PRIORITY_FIXED`, 0: 0 = round-robin on ties; 1 = requester 0 always wins ties.
- `clock` input 1: system clock, all logic on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `r0_valid` input 1: requester 0 byte valid.
- `r0_data` input 8: requester 0 byte.
- `r0_dc` input 1: requester 0 D/C flag (0 = command, 1 = display data).
- `r0_last` input 1: requester 0 final byte of burst.
- `r0_ready` output 1: requester 0 byte accepted this cycle.
- `r1_valid`, `r1_data[7:0]`, `r1_dc`, `r1_last`, `r1_ready`: same as requester 0, for requester 1.
- `spi_start` output 1: byte request to `spi_master`.
- `spi_data` output 8: byte to `spi_master`.
- `spi_dc` output 1: D/C to `spi_master`.
- `spi_avail` input 1: one-cycle pulse from the master meaning the presented byte has been latched.
- `gnt` output 2: one-hot current owner; 00 when idle.
- `active` output 1: high in any state other than IDLE.
- `err` output 1: sticky watchdog flag, cleared only by `Reset`.
- `byte_cnt` output 16: total bytes handed to the master; wraps 0xFFFF to 0x0000.

## Operation
- States are IDLE, LOAD and SEND. All outputs are registered except `r0_ready` and `r1_ready`.
- **IDLE:** `spi_start`=0 and `gnt`=00. Transitions when any `rN_valid` is high:
  - If only one requester is valid, it wins.
  - On a tie with `PRIORITY_FIXED`=0, the winner is the requester not equal to `last_gnt`.
  - On a tie with `PRIORITY_FIXED`=1, requester 0 wins.
  - The winner is written to the owner register and `gnt`, and the state moves to LOAD.
- **LOAD:** `rN_ready` = (state==LOAD) & (owner==N), combinational. On `rN_valid` & `rN_ready`, `data`/`dc`/`last` are latched into hold registers and the state moves to SEND. The burst is locked: the other requester is ignored even if the owner drops `valid`.
- **SEND:** `spi_start`=1, `spi_data`=hold data, `spi_dc`=hold dc. On `spi_avail`:
  - `byte_cnt` increments.
  - If hold last is set: `last_gnt`←owner, state→IDLE.
  - Otherwise: state→LOAD.
  - `spi_start` goes low the following cycle.
- **Watchdog:** a 16-bit counter clears on every state change and increments each cycle in LOAD or SEND. At `TIMEOUT`-1 with no progress: `err`←1, state→IDLE, `gnt`←00, `last_gnt`←owner, and the in-flight byte is discarded (`byte_cnt` is unchanged).
- **Simultaneous events:** `spi_avail` in the same cycle as watchdog expiry counts as progress (normal transition, no `err`). `spi_avail` outside SEND is ignored. `rN_valid` from a non-owner is ignored.
- **Reset values:** state=IDLE, `gnt`=00, `active`=0, `spi_start`=0, `spi_data`=00, `spi_dc`=0, `err`=0, `byte_cnt`=0, `last_gnt`=1 (so requester 0 wins the first tie), hold registers and watchdog=0.
- **Reset mid-operation:** all outputs take reset values immediately, asynchronously. No partial byte or burst resumes.

## Timing
- IDLE with valid at edge k → LOAD at k+1, `gnt` valid at k+1.
- LOAD accept at edge m → SEND at m+1, `spi_start`=1 from m+1.
- `spi_avail` at edge p → `spi_start`=0 and `byte_cnt`+1 at p+1. LOAD (`ready` available) or IDLE at p+1.
- Minimum per byte with data already valid: 2 cycles + master latency. Burst end to next grant: 2 cycles.
- `err` rises exactly `TIMEOUT` cycles after the last state change if no progress occurs.

## Test plan
- **Single burst:** requester 0 sends 0x21, 0x90, 0x20 (dc=0, last on the third byte); master model pulses `spi_avail` 5 cycles after each `spi_start` rise. Required: `spi_data` sequence 0x21, 0x90, 0x20; `gnt`=01 throughout; `byte_cnt`=3; IDLE after the third `spi_avail`.
- **Round-robin:** both requesters assert valid with 1-byte bursts in the first cycle after reset. Required grant order: 0, 1, 0, 1. `spi_data` alternates between the two sources.
- **Burst lock:** requester 0 sends a 2-byte burst with a 10-cycle `valid` gap between bytes while requester 1 holds valid. Required: `r1_ready` stays 0 and `gnt` stays 01 until requester 0's last byte gets `spi_avail`.
- **Watchdog:** `TIMEOUT`=20; the master never pulses `spi_avail`. Required: `err`=1 and `spi_start`=0 20 cycles after entering SEND; state IDLE; `byte_cnt`=0.
- **Reset mid-SEND:** assert `Reset` while `spi_start`=1. Required: `spi_start`=0, `gnt`=00 and `byte_cnt`=0 in the same cycle; on release with both requesters valid, requester 0 is granted.
- **Fixed priority:** `PRIORITY_FIXED`=1 with both requesters continuously valid with 1-byte bursts. Required: only `gnt`=01 observed over 10 bursts.
